// File: rtl/pe_row_ctrl_if.sv
// Bundle of the configuration, run-control and status signals of one PE row
// controller. The controller attaches through the slave modport; whatever
// sequences the row (host or bench) attaches through the master modport.
interface pe_row_ctrl_if #(
    parameter int NUM_PE = 4,
    parameter int INST_W = 64
);
    localparam int NU = NUM_PE + 1;
    localparam int TW = $clog2(NUM_PE + 2);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [TW-1:0]     cfg_target;
    logic [INST_W-1:0] cfg_inst;
    logic              start;
    logic [NU-1:0]     run_mask;
    logic [15:0]       run_len;
    logic              abort;
    logic [NU-1:0]     init_vec;
    logic [INST_W-1:0] pe_config;
    logic [NU-1:0]     run_vec;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output cfg_valid, cfg_target, cfg_inst, start, run_mask, run_len, abort,
        input  cfg_ready, init_vec, pe_config, run_vec, busy, done, err
    );

    modport slave (
        input  cfg_valid, cfg_target, cfg_inst, start, run_mask, run_len, abort,
        output cfg_ready, init_vec, pe_config, run_vec, busy, done, err
    );
endinterface

// File: rtl/pe_row_ctrl.sv
// PE row controller: queues configuration words in a small FIFO, drains them
// as one-hot init strobes while idle, then runs the row for a programmed
// number of cycles. Optional feature macro PE_ROW_CTRL_BROADCAST_EN makes
// target code NUM_PE+1 initialise every unit at once; without it that code
// is treated as an invalid target.
module pe_row_ctrl #(
    parameter int NUM_PE     = 4,
    parameter int INST_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    pe_row_ctrl_if.slave bus
);
    localparam int NU = NUM_PE + 1;
    localparam int TW = $clog2(NUM_PE + 2);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    logic [TW-1:0]     r_tgt_mem  [FIFO_DEPTH];
    logic [INST_W-1:0] r_inst_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    state_t            r_state;
    logic              r_pend;
    logic [NU-1:0]     r_pend_mask;
    logic [15:0]       r_pend_len;
    logic [15:0]       r_cnt;

    logic [NU-1:0]     r_init_vec;
    logic [INST_W-1:0] r_pe_config;
    logic [NU-1:0]     r_run_vec;
    logic              r_done;
    logic              r_err;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [NU-1:0]     w_pop_vec;
    logic              w_launch;
    logic [NU-1:0]     w_go_mask;
    logic [15:0]       w_go_len;

    // Map a target code to its init strobe pattern; all zeros marks an
    // invalid target. Unit k sits at bit NU-1-k (LSU is the MSB).
    function automatic logic [NU-1:0] f_target_vec(input logic [TW-1:0] tgt);
        logic [NU-1:0] v;
        v = '0;
        for (int k = 0; k < NU; k++) begin
            if (tgt == TW'(k)) v[NU-1-k] = 1'b1;
        end
`ifdef PE_ROW_CTRL_BROADCAST_EN
        if (tgt == TW'(NU)) v = '1;
`endif
        return v;
    endfunction

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = bus.cfg_valid && !w_full;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign w_pop_vec = f_target_vec(r_tgt_mem[r_rptr]);

    // A run starts from IDLE once the FIFO is drained: either a pending
    // request, or a fresh start arriving with nothing queued.
    assign w_launch  = (r_state == S_IDLE) && w_empty && (r_pend || bus.start);
    assign w_go_mask = r_pend ? r_pend_mask : bus.run_mask;
    assign w_go_len  = r_pend ? r_pend_len  : bus.run_len;

    assign bus.cfg_ready = !w_full;
    assign bus.busy      = (r_state != S_IDLE) || !w_empty || r_pend;
    assign bus.init_vec  = r_init_vec;
    assign bus.pe_config = r_pe_config;
    assign bus.run_vec   = r_run_vec;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

    // FIFO storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tgt_mem[r_wptr]  <= bus.cfg_target;
            r_inst_mem[r_wptr] <= bus.cfg_inst;
        end
    end

    // FIFO pointers and occupancy; push and pop may happen in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Row sequencer with registered strobes, run enables and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pend      <= 1'b0;
            r_pend_mask <= '0;
            r_pend_len  <= '0;
            r_cnt       <= '0;
            r_init_vec  <= '0;
            r_pe_config <= '0;
            r_run_vec   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_init_vec <= '0;
            if (w_pop) begin
                r_init_vec  <= w_pop_vec;
                r_pe_config <= r_inst_mem[r_rptr];
                if (w_pop_vec == '0) r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_pend <= 1'b0;
                        if (w_go_len == 16'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_RUN;
                            r_cnt     <= w_go_len;
                            r_run_vec <= w_go_mask;
                        end
                    end else if (bus.start && !r_pend) begin
                        r_pend      <= 1'b1;
                        r_pend_mask <= bus.run_mask;
                        r_pend_len  <= bus.run_len;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - 16'd1;
                    if (bus.abort) begin
                        r_state   <= S_IDLE;
                        r_run_vec <= '0;
                    end else if (r_cnt == 16'd1) begin
                        r_state   <= S_DONE;
                        r_run_vec <= '0;
                        r_done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_run_vec <= '0;
                end
            endcase
        end
    end
endmodule
